// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the DIV/TIMA/TMA/TAC timer.
// Consumed by timer (top) and its tick sub-module.
package gb_timer_pkg;

  localparam logic [1:0] OFF_DIV  = 2'd0;
  localparam logic [1:0] OFF_TIMA = 2'd1;
  localparam logic [1:0] OFF_TMA  = 2'd2;
  localparam logic [1:0] OFF_TAC  = 2'd3;

  // Divider bit watched for each TAC[1:0] setting, indexed by TAC[1:0].
  localparam logic [3:0][3:0] TAP_BIT = {4'd7, 4'd5, 4'd3, 4'd9};

  localparam int OVF_DELAY = 4;

  typedef enum logic [1:0] {
    RUN,
    OVF,
    RELOAD
  } state_t;

  function automatic logic [7:0] tac_rd(input logic [2:0] tac);
    return {5'b11111, tac};
  endfunction

endpackage

// File: rtl/timer_tick.sv
// Tap mux and falling-edge detector producing the TIMA increment tick.
// A drop caused by a DIV reset or TAC rewrite counts as an edge too.
module timer_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] taps,
  input  logic [2:0] tac,
  output logic       tick
);

  logic sig;
  logic prev;

  assign sig  = taps[tac[1:0]] & tac[2];
  assign tick = prev & ~sig;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev <= 1'b0;
    end else begin
      prev <= sig;
    end
  end

endmodule

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer with TMA reload and interrupt request.
// Define TIMER_OVF_DELAY_EN for the 4-cycle delayed reload on overflow.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04,
  parameter logic [15:0] CNT_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        wr,
  output logic        int_tim_req
);
  import gb_timer_pkg::*;

  logic [15:0] off;
  logic        hit;
  logic [1:0]  sel;
  logic        we_div;
  logic        we_tima;
  logic        we_tma;
  logic        we_tac;

  logic [15:0] div_cnt;
  logic [2:0]  tac;
  logic [7:0]  tma;
  logic [7:0]  tima;
  logic [7:0]  tima_n;
  state_t      state;
  state_t      state_n;
  logic [3:0]  taps;
  logic        tick;
  logic        unused_rd;

`ifdef TIMER_OVF_DELAY_EN
  logic [1:0]  ovf_cnt;
  logic [1:0]  ovf_cnt_n;
`endif

  // Reads have no side effects, so the strobe is not needed.
  assign unused_rd = rd;

  assign off     = a - BASE_ADDR;
  assign hit     = (off[15:2] == 14'd0);
  assign sel     = off[1:0];
  assign we_div  = wr & hit & (sel == OFF_DIV);
  assign we_tima = wr & hit & (sel == OFF_TIMA);
  assign we_tma  = wr & hit & (sel == OFF_TMA);
  assign we_tac  = wr & hit & (sel == OFF_TAC);

  always_comb begin
    taps = 4'd0;
    for (int i = 0; i < 4; i++) begin
      taps[i] = div_cnt[TAP_BIT[i]];
    end
  end

  timer_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .taps (taps),
    .tac  (tac),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    tima_n  = tima;
`ifdef TIMER_OVF_DELAY_EN
    ovf_cnt_n = ovf_cnt;
`endif
    unique case (state)
      RUN: begin
        if (we_tima) begin
          tima_n = din;
        end else if (tick) begin
          if (tima == 8'hFF) begin
`ifdef TIMER_OVF_DELAY_EN
            tima_n    = 8'h00;
            ovf_cnt_n = 2'd0;
            state_n   = OVF;
`else
            tima_n  = tma;
            state_n = RELOAD;
`endif
          end else begin
            tima_n = tima + 8'd1;
          end
        end
      end
`ifdef TIMER_OVF_DELAY_EN
      OVF: begin
        if (we_tima) begin
          tima_n  = din;
          state_n = RUN;
        end else if (ovf_cnt == 2'(OVF_DELAY - 1)) begin
          tima_n  = we_tma ? din : tma;
          state_n = RELOAD;
        end else begin
          ovf_cnt_n = ovf_cnt + 2'd1;
        end
      end
`endif
      RELOAD: begin
        // TIMA writes lose to the reload; a TMA write lands in TIMA too.
        state_n = RUN;
        if (we_tma) begin
          tima_n = din;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= CNT_RESET;
      tac     <= 3'd0;
      tma     <= 8'h00;
      tima    <= 8'h00;
      state   <= RUN;
    end else begin
      div_cnt <= we_div ? 16'h0000 : div_cnt + 16'd1;
      if (we_tac) begin
        tac <= din[2:0];
      end
      if (we_tma) begin
        tma <= din;
      end
      tima  <= tima_n;
      state <= state_n;
    end
  end

`ifdef TIMER_OVF_DELAY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= 2'd0;
    end else begin
      ovf_cnt <= ovf_cnt_n;
    end
  end
`endif

  assign int_tim_req = (state == RELOAD);

  always_comb begin
    dout = 8'hFF;
    if (hit) begin
      unique case (sel)
        OFF_DIV:  dout = div_cnt[15:8];
        OFF_TIMA: dout = tima;
        OFF_TMA:  dout = tma;
        OFF_TAC:  dout = tac_rd(tac);
        default:  dout = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: register table, then overflow,
// reload, tick and reset corner sequences.
module tb_timer;

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] wa;
    logic [7:0]  wd;
    logic [15:0] ra;
    logic [7:0]  exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;

`ifdef TIMER_OVF_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a   = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        rd  = 1'b0;
  logic        wr  = 1'b0;
  logic [7:0]  dout;
  logic        int_tim_req;

  int passed  = 0;
  int total   = 0;
  int int_cnt = 0;
  sb_t sb[$];
  vec_t vt[11];

  timer dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .din         (din),
    .dout        (dout),
    .rd          (rd),
    .wr          (wr),
    .int_tim_req (int_tim_req)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (int_tim_req === 1'b1) int_cnt++;
  end

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h", name, got, exp);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] addr,
                        input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    a  = addr;
    rd = 1'b1;
    #1;
    e = sb.pop_front();
    check(e.name, dout, e.exp);
    rd = 1'b0;
    a  = 16'h0000;
  endtask

  task automatic int_chk(input string name, input logic exp);
    check(name, {7'd0, int_tim_req}, {7'd0, exp});
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
    a   = addr;
    din = data;
    wr  = 1'b1;
    @(negedge clk);
    wr  = 1'b0;
    a   = 16'h0000;
    din = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Leaves DIV cleared one cycle before TAC=5 takes effect.
  task automatic start_run(input logic [7:0] t0, input logic [7:0] m0);
    do_reset();
    bus_write(A_TIMA, t0);
    bus_write(A_TMA, m0);
    bus_write(A_DIV, 8'h00);
    bus_write(A_TAC, 8'h05);
  endtask

  initial begin
    int c0;

    vt[0]  = '{"tma_rw",      1'b1, A_TMA,    8'hA5, A_TMA,    8'hA5};
    vt[1]  = '{"tac_rw_2",    1'b1, A_TAC,    8'hFA, A_TAC,    8'hFA};
    vt[2]  = '{"tac_rw_3",    1'b1, A_TAC,    8'h03, A_TAC,    8'hFB};
    vt[3]  = '{"rd_below",    1'b0, 16'h0000, 8'h00, 16'hFF03, 8'hFF};
    vt[4]  = '{"rd_above",    1'b0, 16'h0000, 8'h00, 16'hFF08, 8'hFF};
    vt[5]  = '{"wr_above",    1'b1, 16'hFF08, 8'h12, A_TMA,    8'hA5};
    vt[6]  = '{"tima_rw",     1'b1, A_TIMA,   8'h3C, A_TIMA,   8'h3C};
    vt[7]  = '{"wr_below",    1'b1, 16'hFF03, 8'h00, A_TIMA,   8'h3C};
    vt[8]  = '{"tac_clear",   1'b1, A_TAC,    8'h00, A_TAC,    8'hF8};
    vt[9]  = '{"div_wr_data", 1'b1, A_DIV,    8'hAA, A_DIV,    8'h00};
    vt[10] = '{"tma_zero",    1'b1, A_TMA,    8'h00, A_TMA,    8'h00};

    @(negedge clk);
    do_reset();
    rd_chk("rst_tima", A_TIMA, 8'h00);
    rd_chk("rst_tma", A_TMA, 8'h00);
    rd_chk("rst_tac", A_TAC, 8'hF8);
    rd_chk("rst_div", A_DIV, 8'h00);
    int_chk("rst_int", 1'b0);

    foreach (vt[i]) begin
      if (vt[i].wr) bus_write(vt[i].wa, vt[i].wd);
      rd_chk(vt[i].name, vt[i].ra, vt[i].exp);
    end

    // DIV rollover into the upper byte, then DIV clear
    do_reset();
    repeat (255) @(negedge clk);
    rd_chk("div_255", A_DIV, 8'h00);
    @(negedge clk);
    rd_chk("div_256", A_DIV, 8'h01);
    bus_write(A_DIV, 8'h5A);
    rd_chk("div_clear", A_DIV, 8'h00);

    // overflow with reload from TMA
    start_run(8'hFE, 8'h80);
    c0 = int_cnt;
    repeat (15) @(negedge clk);
    rd_chk("ovf_pre_tick", A_TIMA, 8'hFE);
    @(negedge clk);
    rd_chk("ovf_tick1", A_TIMA, 8'hFF);
    repeat (15) @(negedge clk);
    rd_chk("ovf_pre_wrap", A_TIMA, 8'hFF);
    @(negedge clk);
    if (DLY > 0) begin
      rd_chk("ovf_wrap_00", A_TIMA, 8'h00);
      int_chk("ovf_wrap_int", 1'b0);
      repeat (3) @(negedge clk);
      rd_chk("ovf_last_00", A_TIMA, 8'h00);
      int_chk("ovf_last_int", 1'b0);
      @(negedge clk);
    end
    rd_chk("reload_tima", A_TIMA, 8'h80);
    int_chk("reload_int", 1'b1);
    @(negedge clk);
    int_chk("post_reload_int", 1'b0);
    rd_chk("post_reload_tima", A_TIMA, 8'h80);
    repeat (3) @(negedge clk);
    check("ovf_pulse_count", 8'(int_cnt - c0), 8'd1);

    // TIMA write racing the overflow sequence
    start_run(8'hFF, 8'h80);
    c0 = int_cnt;
    repeat (16) @(negedge clk);
`ifdef TIMER_OVF_DELAY_EN
    rd_chk("ovfwr_in_ovf", A_TIMA, 8'h00);
    bus_write(A_TIMA, 8'h33);
    rd_chk("ovfwr_tima", A_TIMA, 8'h33);
    repeat (8) @(negedge clk);
    rd_chk("ovfwr_hold", A_TIMA, 8'h33);
    check("ovfwr_no_int", 8'(int_cnt - c0), 8'd0);
`else
    rd_chk("relwr_in_reload", A_TIMA, 8'h80);
    bus_write(A_TIMA, 8'h33);
    rd_chk("relwr_ignored", A_TIMA, 8'h80);
    repeat (3) @(negedge clk);
    check("relwr_one_int", 8'(int_cnt - c0), 8'd1);
`endif

    // TMA write during the reload cycle
    start_run(8'hFF, 8'h80);
    repeat (16 + DLY) @(negedge clk);
    int_chk("tmawr_reload_int", 1'b1);
    bus_write(A_TMA, 8'h55);
    rd_chk("tmawr_tima", A_TIMA, 8'h55);
    rd_chk("tmawr_tma", A_TMA, 8'h55);
    int_chk("tmawr_int_done", 1'b0);

    // TIMA write on the tick cycle wins over the increment
    start_run(8'h10, 8'h00);
    repeat (15) @(negedge clk);
    bus_write(A_TIMA, 8'h77);
    rd_chk("wr_vs_tick", A_TIMA, 8'h77);
    repeat (16) @(negedge clk);
    rd_chk("tick_after_wr", A_TIMA, 8'h78);

    // DIV write drops the bit-9 tap: one extra tick
    do_reset();
    bus_write(A_TIMA, 8'h10);
    bus_write(A_DIV, 8'h00);
    repeat (600) @(negedge clk);
    bus_write(A_TAC, 8'h04);
    bus_write(A_DIV, 8'h00);
    rd_chk("divtick_before", A_TIMA, 8'h10);
    @(negedge clk);
    rd_chk("divtick_inc", A_TIMA, 8'h11);
    repeat (20) @(negedge clk);
    rd_chk("divtick_once", A_TIMA, 8'h11);

    // asynchronous reset in the middle of the overflow window
    start_run(8'hFF, 8'h80);
    repeat (17) @(negedge clk);
    c0 = int_cnt;
    #2;
    rst = 1'b0;
    rd_chk("arst_tima", A_TIMA, 8'h00);
    rd_chk("arst_tma", A_TMA, 8'h00);
    rd_chk("arst_tac", A_TAC, 8'hF8);
    rd_chk("arst_div", A_DIV, 8'h00);
    int_chk("arst_int", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("arst_no_pulse", 8'(int_cnt - c0), 8'd0);
    rd_chk("arst_tima_hold", A_TIMA, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
